// File: rtl/bcd_pkg.sv
// Shared types and constants for the round-robin binary-to-BCD conversion scheduler.
package bcd_pkg;

  localparam int unsigned BIN_W  = 8;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned N_ITER = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  // Double-dabble correction: every digit >= 5 gets +3 before the next left shift.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    for (int i = 0; i < int'(BCD_W / 4); i++) begin
      if (d[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_sched_if.sv
// Requester-side bus of the BCD scheduler: level requests in, one-hot acks and result out.
interface bcd_sched_if
  import bcd_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
);

  logic [N_REQ-1:0]       req;
  logic [BIN_W*N_REQ-1:0] din;
  logic [N_REQ-1:0]       ack;
  logic [BCD_W-1:0]       bcd_out;
  logic                   bcd_valid;
  logic [ID_W-1:0]        bcd_id;
  logic                   busy;

  modport slave (
    input  req,
    input  din,
    output ack,
    output bcd_out,
    output bcd_valid,
    output bcd_id,
    output busy
  );

  modport master (
    output req,
    output din,
    input  ack,
    input  bcd_out,
    input  bcd_valid,
    input  bcd_id,
    input  busy
  );

endinterface

// File: rtl/bcd_core.sv
// Shift-add-3 converter: loads bin on start, runs N_ITER iterations, flags the last one with done.
module bcd_core
  import bcd_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam logic [3:0] CntLast = 4'(N_ITER - 1);

  // {digits, operand} shifted together; the operand MSB feeds the units LSB.
  logic [BCD_W+BIN_W-1:0] sh_q, sh_d;
  logic [3:0]             cnt_q;
  logic                   active_q;

  always_comb begin
    sh_d = {add3_digits(sh_q[BIN_W +: BCD_W]), sh_q[BIN_W-1:0]} << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start) begin
      sh_q     <= {{BCD_W{1'b0}}, bin};
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      sh_q <= sh_d;
      if (cnt_q == CntLast) begin
        cnt_q    <= '0;
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end
  end

  // High during the final iteration so the scheduler leaves SHIFT on that edge.
  assign done = active_q && (cnt_q == CntLast);
  assign bcd  = sh_q[BIN_W +: BCD_W];

endmodule

// File: rtl/bcd_sched.sv
// Round-robin arbiter plus IDLE/SHIFT/DONE FSM sharing one bcd_core among N_REQ requesters.
module bcd_sched
  import bcd_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input logic            clk,
  input logic            rst,
  bcd_sched_if.slave     bus
);

  state_e           state_q;
  logic [ID_W-1:0]  id_q;
  logic [ID_W-1:0]  last_id_q;
  logic [N_REQ-1:0] ack_q;
  logic             valid_q;
  logic [BCD_W-1:0] bcd_q;
  logic [ID_W-1:0]  bcd_id_q;

  logic [N_REQ-1:0]   req_eff;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [ID_W:0]      rot_amt;
  int unsigned        pos;
  logic               grant_vld;
  logic [ID_W-1:0]    grant_idx;
  logic [BIN_W-1:0]   grant_bin;
  logic               start;
  logic               core_done;
  logic [BCD_W-1:0]   core_bcd;

  // The lane acked in this cycle still shows its old req; it may only be granted after it reacts.
  assign req_eff = bus.req & ~ack_q;
  assign req_dbl = {req_eff, req_eff};
  // last_id+1 reaching N_REQ shifts by a full width, which is the same as no rotation.
  assign rot_amt = {1'b0, last_id_q} + 1'b1;
  assign req_rot = N_REQ'(req_dbl >> rot_amt);

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    pos       = 0;
    for (int j = 0; j < int'(N_REQ); j++) begin
      if (!grant_vld && req_rot[j]) begin
        grant_vld = 1'b1;
        pos       = 32'(last_id_q) + unsigned'(j) + 1;
        grant_idx = ID_W'(pos % N_REQ);
      end
    end
  end

  always_comb begin
    grant_bin = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_idx == ID_W'(i)) begin
        grant_bin = bus.din[BIN_W*i +: BIN_W];
      end
    end
  end

  // The core captures the operand on the grant edge itself; din is ignored afterwards.
  assign start = (state_q == StIdle) && grant_vld;

  bcd_core u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (grant_bin),
    .done  (core_done),
    .bcd   (core_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      id_q      <= '0;
      last_id_q <= ID_W'(N_REQ - 1);
      ack_q     <= '0;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      bcd_id_q  <= '0;
    end else begin
      ack_q   <= '0;
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            id_q    <= grant_idx;
            state_q <= StShift;
          end
        end
        StShift: begin
          if (core_done) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          ack_q     <= N_REQ'(1) << id_q;
          valid_q   <= 1'b1;
          bcd_q     <= core_bcd;
          bcd_id_q  <= id_q;
          last_id_q <= id_q;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.bcd_valid = valid_q;
  assign bus.bcd_out   = bcd_q;
  assign bus.bcd_id    = bcd_id_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_bcd_sched.sv
// Directed and randomized checks of bcd_sched against an arithmetic/round-robin reference model.
module tb_bcd_sched;

  localparam int N  = 4;
  localparam int LAT = 9;
  localparam int BOUND = 12 * N + 12;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  bcd_sched_if #(.N_REQ(N), .ID_W(2)) bus ();

  bcd_sched #(.N_REQ(N), .ID_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] to_bcd(input int unsigned v);
    return 12'(((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] a);
    for (int i = 0; i < N; i++) if (a[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic r, input logic [7:0] v);
    bus.req[l]       = r;
    bus.din[8*l +: 8] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    bus.req = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Assumes req[l] was raised at the previous negedge while idle, so the grant is the next edge.
  task automatic run_conv(input int l, input logic [11:0] exp, input string tag,
                          input int chg_k, input logic [7:0] chg_v, input int drop_k);
    int early;
    early = 0;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      if (k == 0) chk({tag, "_busy"}, 32'(bus.busy), 1);
      if (k < LAT && bus.ack != '0) early++;
      if (k == chg_k) bus.din[8*l +: 8] = chg_v;
      if (k == drop_k) bus.req[l] = 1'b0;
      if (k == LAT) begin
        chk({tag, "_early"}, early, 0);
        chk({tag, "_ack"}, 32'(bus.ack), 32'(1) << l);
        chk({tag, "_valid"}, 32'(bus.bcd_valid), 1);
        chk({tag, "_out"}, 32'(bus.bcd_out), 32'(exp));
        chk({tag, "_id"}, 32'(bus.bcd_id), l);
        bus.req[l] = 1'b0;
      end
    end
    @(negedge clk);
    chk({tag, "_pulse"}, {31'(bus.ack), bus.bcd_valid}, 0);
  endtask

  task automatic wait_ack(output int lane, output logic [11:0] val);
    lane = -1;
    val  = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        lane = onehot_idx(bus.ack);
        val  = bus.bcd_out;
        break;
      end
    end
  endtask

  int          ack_lane[N];
  int          ack_cyc[N];
  logic [11:0] ack_val[N];
  int          n_ack;
  int          lane;
  logic [11:0] val;
  int          bnd_op[6] = '{0, 9, 10, 99, 100, 199};
  logic [11:0] bnd_exp[6] = '{12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h199};
  bit          pend[N];
  int          since[N];
  logic [7:0]  op[N];
  int          last;
  int          cyc;
  int          g;
  int          e;
  int          idx;
  int          any_pend;

  initial begin
    rst     = 1'b1;
    bus.req = '0;
    bus.din = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_valid", 32'(bus.bcd_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_out", 32'(bus.bcd_out), 0);
    chk("rst_id", 32'(bus.bcd_id), 0);
    rst = 1'b0;

    // Single lane, max operand.
    @(negedge clk);
    set_lane(0, 1'b1, 8'd255);
    run_conv(0, 12'h255, "single", -1, 8'd0, -1);

    // Boundary operands spread across lanes.
    for (int i = 0; i < 6; i++) begin
      set_lane(i % N, 1'b1, 8'(bnd_op[i]));
      run_conv(i % N, bnd_exp[i], $sformatf("bnd%0d", bnd_op[i]), -1, 8'd0, -1);
      chk($sformatf("bnd_model%0d", i), 32'(to_bcd(bnd_op[i])), 32'(bnd_exp[i]));
    end

    // All four lanes at once after reset: served 0,1,2,3, ten cycles apart.
    do_reset();
    for (int i = 0; i < N; i++) set_lane(i, 1'b1, 8'(i + 1));
    n_ack = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.ack != '0 && n_ack < N) begin
        ack_lane[n_ack] = onehot_idx(bus.ack);
        ack_cyc[n_ack]  = c;
        ack_val[n_ack]  = bus.bcd_out;
        chk("all4_id", 32'(bus.bcd_id), ack_lane[n_ack]);
        bus.req[ack_lane[n_ack]] = 1'b0;
        n_ack++;
      end
    end
    chk("all4_count", n_ack, N);
    for (int i = 0; i < N; i++) begin
      if (i < n_ack) begin
        chk($sformatf("all4_lane%0d", i), ack_lane[i], i);
        chk($sformatf("all4_val%0d", i), 32'(ack_val[i]), 32'(to_bcd(i + 1)));
        chk($sformatf("all4_cyc%0d", i), ack_cyc[i], LAT + 10 * i);
      end
    end

    // Fairness: lane 0 re-requests at its ack while lane 2 waits.
    do_reset();
    set_lane(0, 1'b1, 8'd11);
    repeat (3) @(negedge clk);
    set_lane(2, 1'b1, 8'd22);
    wait_ack(lane, val);
    chk("fair_first", lane, 0);
    chk("fair_first_val", 32'(val), 32'(to_bcd(11)));
    set_lane(0, 1'b1, 8'd33);
    wait_ack(lane, val);
    chk("fair_second", lane, 2);
    chk("fair_second_val", 32'(val), 32'(to_bcd(22)));
    set_lane(2, 1'b0, 8'd22);
    wait_ack(lane, val);
    chk("fair_third", lane, 0);
    chk("fair_third_val", 32'(val), 32'(to_bcd(33)));
    set_lane(0, 1'b0, 8'd33);
    @(negedge clk);

    // din changes after grant and req drops mid-SHIFT: captured operand wins, ack still pulses.
    set_lane(1, 1'b1, 8'd123);
    run_conv(1, 12'h123, "midchg", 2, 8'd45, 4);

    // Reset during SHIFT aborts with no ack; held req[1] is re-served with full latency.
    set_lane(1, 1'b1, 8'd77);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("abort_noack%0d", k), 32'(bus.ack), 0);
    end
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_out", 32'(bus.bcd_out), 0);
    chk("abort_valid", 32'(bus.bcd_valid), 0);
    chk("abort_id", 32'(bus.bcd_id), 0);
    @(negedge clk);
    chk("abort_ack_in_rst", 32'(bus.ack), 0);
    rst = 1'b0;
    run_conv(1, to_bcd(77), "after_rst", -1, 8'd0, -1);

    // Randomized traffic against a round-robin model keyed on when each request became visible.
    do_reset();
    for (int i = 0; i < N; i++) begin
      pend[i]  = 1'b0;
      since[i] = 0;
      op[i]    = '0;
    end
    last = N - 1;
    cyc  = 0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      cyc++;
      chk("rnd_valid", 32'(bus.bcd_valid), 32'(|bus.ack));
      if (bus.ack != '0) begin
        lane = onehot_idx(bus.ack);
        chk("rnd_onehot", $countones(bus.ack), 1);
        g = cyc - LAT;
        e = -1;
        for (int k = 1; k <= N; k++) begin
          idx = (last + k) % N;
          if (e < 0 && pend[idx] && since[idx] <= g) e = idx;
        end
        chk("rnd_lane", lane, e);
        chk("rnd_val", 32'(bus.bcd_out), 32'(to_bcd(op[lane])));
        chk("rnd_id", 32'(bus.bcd_id), lane);
        last = lane;
        if (c < 800 && $urandom_range(1, 0) == 1) begin
          op[lane]    = 8'($urandom);
          since[lane] = cyc + 1;
          set_lane(lane, 1'b1, op[lane]);
        end else begin
          pend[lane] = 1'b0;
          bus.req[lane] = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (pend[i] && (cyc - since[i]) > BOUND) begin
          chk($sformatf("rnd_starve%0d", i), cyc - since[i], BOUND);
          since[i] = cyc;
        end
        if (c < 800 && !pend[i] && $urandom_range(7, 0) == 0) begin
          op[i]    = 8'($urandom);
          since[i] = cyc + 1;
          pend[i]  = 1'b1;
          set_lane(i, 1'b1, op[i]);
        end
      end
    end
    any_pend = 0;
    for (int i = 0; i < N; i++) if (pend[i]) any_pend++;
    chk("rnd_drain", any_pend, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_sched.md
BCD_SCHED -- requirements
Module: bcd_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters; legal range 2..8.
REQ-002 Parameter ID_W, default 2, requester index width; SHALL equal clog2(N_REQ).
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req  input  N_REQ  per-requester conversion request, level.
REQ-006 din  input  8*N_REQ  binary operands; lane i is din[8i+7:8i].
REQ-007 ack  output  N_REQ  one-hot, one-cycle completion pulse.
REQ-008 bcd_out  output  12  result digits: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-009 bcd_valid  output  1  one-cycle pulse, coincident with ack.
REQ-010 bcd_id  output  ID_W  index of the requester that owns bcd_out.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 IDLE with any req high: at the next edge, grant one lane round-robin, capture its din lane and its index, go to SHIFT.
REQ-014 Round-robin search SHALL start at last_id+1 modulo N_REQ, where last_id is the most recently acknowledged lane.
REQ-015 SHIFT SHALL last exactly 8 cycles (4-bit iteration counter, 0..7); after iteration 7 go to DONE.
REQ-016 Each iteration SHALL first add 3 to every BCD digit >=5, then shift {digits, operand} left by 1, operand MSB entering the units LSB.
REQ-017 DONE SHALL last one cycle; during it: ack[id]=1, bcd_valid=1, bcd_id=id, bcd_out=converted value; then go to IDLE.
REQ-018 Latency: a grant at edge t SHALL give ack and bcd_valid high in the cycle after edge t+9; throughput is one conversion per 10 cycles.
REQ-019 bcd_out and bcd_id SHALL be registered and hold their value until the next DONE.
REQ-020 Requester protocol: hold req and din stable until ack is seen, then drop req at the following edge or present a new operand.
REQ-021 din SHALL be sampled only at the grant edge; later changes on din SHALL NOT affect the result.
REQ-022 A req dropped mid-conversion SHALL NOT abort it; the conversion completes and ack is still pulsed.
REQ-023 A req arriving while busy SHALL wait; it is considered only in IDLE, so no request is lost.
REQ-024 No lane SHALL be granted again while another lane with req high is waiting (bounded wait of N_REQ-1 conversions).
REQ-025 Operand range is 0..255; every result SHALL be valid BCD (each digit <=9, hundreds <=2).

Reset
REQ-026 While rst is high: state=IDLE, counter=0, ack=0, bcd_valid=0, busy=0, bcd_out=12'h000, bcd_id=0, last_id=N_REQ-1.
REQ-027 Reset asserted mid-conversion SHALL abort it immediately with no ack.
REQ-028 After rst deasserts, the first grant SHALL go to the lowest-index active lane.

Structure
REQ-029 Package bcd_pkg SHALL hold: the state enumeration, BIN_W=8, BCD_W=12, N_ITER=8.
REQ-030 Sub-module bcd_core SHALL contain the shift-add-3 datapath and iteration counter, with ports clk, rst, start, bin[7:0], done, bcd[11:0].
REQ-031 bcd_sched SHALL contain the arbiter, the FSM, and the output registers.

Verification
REQ-032 Single lane: reset, req[0]=1 with din lane0=8'd255 -> ack[0] 9 cycles after grant, bcd_out=12'h255, bcd_id=0.
REQ-033 Boundary operands: din=0, 9, 10, 99, 100, 199 -> bcd_out=12'h000, 12'h009, 12'h010, 12'h099, 12'h100, 12'h199.
REQ-034 All four req high with operands 1, 2, 3, 4 -> acks for lanes 0, 1, 2, 3 in that order, 10 cycles apart, with bcd_out 12'h001..12'h004 matching bcd_id.
REQ-035 Fairness: lane 0 re-requests immediately after its ack while lane 2 is pending -> lane 2 is acknowledged before lane 0 again.
REQ-036 Mid-conversion changes: din changes after grant, or req drops mid-SHIFT -> result equals the operand captured at grant, and ack is still pulsed.
REQ-037 Reset in SHIFT cycle 4 -> same cycle: busy=0, bcd_out=12'h000; no ack; after release a held req[1] is re-served with full 9-cycle latency.
